// File: rtl/me_control_if.sv
// me_control_if: start/status handshake, memory addresses and comparator-result
// bundle between the motion-estimation controller and its datapath.
interface me_control_if;
    logic        go;
    logic        busy;
    logic        done;
    logic        CompStart;
    logic [15:0] PEready;
    logic [3:0]  VectorX;
    logic [3:0]  VectorY;
    logic [15:0] NewDist;
    logic [7:0]  AddressR;
    logic [9:0]  AddressS1;
    logic [9:0]  AddressS2;
    logic [15:0] S1S2mux;
    modport master (
        input  go,
        output busy, done, CompStart, PEready, VectorX, VectorY,
               NewDist, AddressR, AddressS1, AddressS2, S1S2mux
    );
    modport slave (
        output go,
        input  busy, done, CompStart, PEready, VectorX, VectorY,
               NewDist, AddressR, AddressS1, AddressS2, S1S2mux
    );
endinterface

// File: rtl/me_control.sv
// me_control: sequences one 16x16 full search over 256 candidate vectors on 16 PEs,
// driving R/S memory addresses, PE clears/selects and comparator result lines.
module me_control (
    input logic          clock,
    input logic          reset_n,
    me_control_if.master bus
);
    typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;
    localparam logic [12:0] LAST = 13'd4111;
    state_t      state;
    logic [12:0] c;
    logic        comp_start;
    logic        run;
    logic        in_blk;
    logic        ready;
    logic [4:0]  srow;
    logic [15:0] new_dist;
    logic [15:0] s1s2;
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state      <= IDLE;
            c          <= '0;
            comp_start <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.go) begin
                    state      <= CLEAR;
                    comp_start <= 1'b0;
                end
                CLEAR: begin
                    state      <= RUN;
                    c          <= '0;
                    comp_start <= 1'b1;
                end
                RUN: begin
                    state <= c == LAST ? DONE : RUN;
                    c     <= c == LAST ? '0 : c + 13'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end
    assign run    = state == RUN;
    assign in_blk = run && !c[12];
    // a PE's SAD is ready the cycle after its 256-pixel window closes
    assign ready  = run && c[12:8] != 5'd0 && c[7:4] == 4'd0;
    assign srow   = 5'(c[11:8]) + 5'(c[7:4]);
    for (genvar k = 0; k < 16; k++) begin : g_pe
        assign new_dist[k] = in_blk && c[7:0] == 8'(k);
        // PE k reads S1 while its current window column k + (pixel column) stays below 16
        assign s1s2[k] = run && (5'(4'(c[3:0] - 4'(k))) + 5'(k) < 5'd16) && c < 13'd4096 + 13'(k);
    end
    assign bus.busy      = state == CLEAR || run;
    assign bus.done      = state == DONE;
    assign bus.CompStart = comp_start;
    assign bus.PEready   = ready ? 16'd1 << c[3:0] : '0;
    assign bus.VectorX   = ready ? c[3:0] : '0;
    assign bus.VectorY   = ready ? c[11:8] - 4'd1 : '0;
    assign bus.NewDist   = new_dist;
    assign bus.AddressR  = in_blk ? c[7:0] : '0;
    assign bus.AddressS1 = in_blk ? {srow, 1'b0, c[3:0]} : '0;
    assign bus.AddressS2 = in_blk ? {srow, 1'b1, c[3:0]} : '0;
    assign bus.S1S2mux   = s1s2;
endmodule

// File: tb/tb_me_control.sv
// tb_me_control: randomized bench for me_control against a PE-schedule reference
// model, closed loop with a behavioural comparator and SAD table.
module tb_me_control;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int checks = 0;
    int errors = 0;
    int ready_cnt;
    logic [7:0] sad [16][16];
    logic [7:0] best = 8'h00;
    logic [3:0] mx = 4'd0;
    logic [3:0] my = 4'd0;
    me_control_if bus ();
    me_control dut (.clock(clock), .reset_n(reset_n), .bus(bus.master));
    always #5 clock = ~clock;
    always @(posedge clock) begin
        if (!bus.CompStart) best <= 8'hFF;
        else if (bus.PEready != 16'd0 && sad[bus.VectorY][bus.VectorX] < best) begin
            best <= sad[bus.VectorY][bus.VectorX];
            mx   <= bus.VectorX;
            my   <= bus.VectorY;
        end
    end
    task automatic tick;
        @(posedge clock);
        #1;
    endtask
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp, input int c);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at c=%0d observed=%0h expected=%0h", tag, c, obs, exp);
        end
    endtask
    // ph: 0 idle, 1 clear, 2 run, 3 done; PE k works on (x=k, y=r) over c = 256r+k .. 256r+k+255
    task automatic check_out(input int ph, input int c, input bit cs);
        logic [15:0] nd, rdy, mux;
        logic [3:0] vx, vy;
        logic [7:0] ar;
        logic [9:0] s1, s2;
        int p, srow;
        nd = 0; rdy = 0; mux = 0; vx = 0; vy = 0; ar = 0; s1 = 0; s2 = 0;
        if (ph == 2) begin
            for (int k = 0; k < 16; k++) begin
                if (c >= k && c <= 4095 + k) begin
                    p = (c - k) % 256;
                    if (p == 0) nd[k] = 1'b1;
                    if (k + p % 16 < 16) mux[k] = 1'b1;
                end
            end
            if (c >= 256 && c % 256 < 16) begin
                rdy[c % 256] = 1'b1;
                vx = 4'(c % 256);
                vy = 4'(c / 256 - 1);
            end
            if (c < 4096) begin
                srow = c / 256 + (c % 256) / 16;
                ar = 8'(c % 256);
                s1 = 10'(srow * 32 + c % 16);
                s2 = 10'(srow * 32 + 16 + c % 16);
            end
        end
        check("busy", bus.busy, ph == 1 || ph == 2, c);
        check("done", bus.done, ph == 3, c);
        check("CompStart", bus.CompStart, cs, c);
        check("PEready", bus.PEready, rdy, c);
        check("VectorX", bus.VectorX, vx, c);
        check("VectorY", bus.VectorY, vy, c);
        check("NewDist", bus.NewDist, nd, c);
        check("AddressR", bus.AddressR, ar, c);
        check("AddressS1", bus.AddressS1, s1, c);
        check("AddressS2", bus.AddressS2, s2, c);
        check("S1S2mux", bus.S1S2mux, mux, c);
    endtask
    task automatic run(input int rst_at, input bit noise);
        for (int y = 0; y < 16; y++)
            for (int x = 0; x < 16; x++)
                sad[y][x] = 8'($urandom_range(4, 254));
        sad[5][9] = 8'h03;
        ready_cnt = 0;
        bus.go = 1'b1;
        tick;
        bus.go = 1'b0;
        check_out(1, -1, 1'b0);
        for (int c = 0; c < 4112; c++) begin
            tick;
            check_out(2, c, 1'b1);
            if (bus.PEready != 16'd0) ready_cnt++;
            if (c == 0) check("best_cleared", best, 8'hFF, c);
            if (c == rst_at) begin
                reset_n = 1'b0;
                bus.go = 1'b0;
                tick;
                reset_n = 1'b1;
                check_out(0, -1, 1'b0);
                return;
            end
            if (noise) bus.go = (c == 1000 || c == 4111) ? 1'b1 : 1'($urandom_range(0, 1));
        end
        tick;
        bus.go = noise;
        check_out(3, 4112, 1'b1);
        check("ready_count", ready_cnt, 256, 4112);
        check("BestDist", best, 8'h03, 4112);
        check("motionX", mx, 4'd9, 4112);
        check("motionY", my, 4'd5, 4112);
        tick;
        bus.go = 1'b0;
        check_out(0, -1, 1'b1);
    endtask
    initial begin
        bus.go = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.go = 1'($urandom_range(0, 1));
            tick;
            check_out(0, -1, 1'b0);
        end
        bus.go = 1'b0;
        reset_n = 1'b1;
        repeat ($urandom_range(1, 5)) begin
            tick;
            check_out(0, -1, 1'b0);
        end
        run(-1, 1'b1);
        run(-1, 1'b0);
        run(2000, 1'b1);
        repeat (2) begin
            tick;
            check_out(0, -1, 1'b0);
        end
        run(-1, 1'b1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
